interval_timer: RTL and testbench



---
 rtl/interval_timer.sv | 141 ++++++++++++++
 tb/tb_interval_timer.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/interval_timer.sv
// interval_timer: programmable BASE/EXT/YEL interval store with a
// one-second countdown that pulses `expired` once per loaded interval.
// Optional feature macro REMAIN_OUT_EN adds time_remaining and sec_tick taps.
module interval_timer #(
  parameter int unsigned CLK_DIV      = 100000000,
  parameter int unsigned VALUE_W      = 4,
  parameter int unsigned BASE_DEFAULT = 6,
  parameter int unsigned EXT_DEFAULT  = 3,
  parameter int unsigned YEL_DEFAULT  = 2
) (
  input  logic               clk,
  input  logic               sys_reset,
  input  logic               prg_sync_in,
  input  logic [1:0]         time_param_sel,
  input  logic [VALUE_W-1:0] time_value,
  input  logic               start_timer,
  input  logic [1:0]         interval_address,
`ifdef REMAIN_OUT_EN
  output logic [VALUE_W-1:0] time_remaining,
  output logic               sec_tick,
`endif
  output logic               expired
);

  localparam int unsigned DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0]   DIV_MAX  = DIV_W'(CLK_DIV - 1);
  localparam logic [VALUE_W-1:0] BASE_DEF = VALUE_W'(BASE_DEFAULT);
  localparam logic [VALUE_W-1:0] EXT_DEF  = VALUE_W'(EXT_DEFAULT);
  localparam logic [VALUE_W-1:0] YEL_DEF  = VALUE_W'(YEL_DEFAULT);
  localparam logic [VALUE_W-1:0] ONE      = VALUE_W'(1);

  typedef enum logic {
    S_IDLE,
    S_RUN
  } state_t;

  state_t             state_q, state_d;
  logic [VALUE_W-1:0] base_q, ext_q, yel_q;
  logic [VALUE_W-1:0] base_d, ext_d, yel_d;
  logic [VALUE_W-1:0] remain_q, remain_d;
  logic [DIV_W-1:0]   div_q, div_d;
  logic               expired_q, expired_d;
  logic [VALUE_W-1:0] prog_val;
  logic [VALUE_W-1:0] load_val;
  logic               tick;

  // Interval store update; the next-state values feed the load mux so a
  // same-cycle program and start sees the newly written value.
  always_comb begin
    prog_val = (time_value == '0) ? ONE : time_value;
    base_d   = base_q;
    ext_d    = ext_q;
    yel_d    = yel_q;
    if (prg_sync_in) begin
      case (time_param_sel)
        2'b00:   base_d = prog_val;
        2'b01:   ext_d  = prog_val;
        2'b10:   yel_d  = prog_val;
        default: begin
          base_d = BASE_DEF;
          ext_d  = EXT_DEF;
          yel_d  = YEL_DEF;
        end
      endcase
    end
  end

  // Select the interval to load; address 11 falls back to BASE.
  always_comb begin
    case (interval_address)
      2'b01:   load_val = ext_d;
      2'b10:   load_val = yel_d;
      default: load_val = base_d;
    endcase
  end

  assign tick = (state_q == S_RUN) && (div_q == DIV_MAX);

  // Countdown next-state: a start always wins over the final tick, which
  // is what cancels any in-flight expiry.
  always_comb begin
    state_d   = state_q;
    remain_d  = remain_q;
    div_d     = div_q;
    expired_d = 1'b0;
    if (start_timer) begin
      state_d  = S_RUN;
      remain_d = load_val;
      div_d    = '0;
    end else if (state_q == S_RUN) begin
      if (tick) begin
        div_d = '0;
        if (remain_q > ONE) begin
          remain_d = remain_q - ONE;
        end else begin
          remain_d  = '0;
          state_d   = S_IDLE;
          expired_d = 1'b1;
        end
      end else begin
        div_d = div_q + DIV_W'(1);
      end
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (sys_reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Datapath registers: stored intervals, remaining seconds, divider, pulse.
  always_ff @(posedge clk) begin
    if (sys_reset) begin
      base_q    <= BASE_DEF;
      ext_q     <= EXT_DEF;
      yel_q     <= YEL_DEF;
      remain_q  <= '0;
      div_q     <= '0;
      expired_q <= 1'b0;
    end else begin
      base_q    <= base_d;
      ext_q     <= ext_d;
      yel_q     <= yel_d;
      remain_q  <= remain_d;
      div_q     <= div_d;
      expired_q <= expired_d;
    end
  end

  assign expired = expired_q;

`ifdef REMAIN_OUT_EN
  assign time_remaining = remain_q;
  assign sec_tick       = tick;
`endif

endmodule

// File: tb/tb_interval_timer.sv
// tb_interval_timer: scoreboard bench for interval_timer with CLK_DIV=4.
// Expected expiry cycles are queued when a start is driven and compared
// whenever the DUT pulses expired.
module tb_interval_timer;

  localparam int unsigned DIV = 4;

  logic       clk = 1'b0;
  logic       sys_reset = 1'b1;
  logic       prg_sync_in = 1'b0;
  logic [1:0] time_param_sel = 2'b00;
  logic [3:0] time_value = 4'd0;
  logic       start_timer = 1'b0;
  logic [1:0] interval_address = 2'b00;
  logic       expired;

  int unsigned cyc = 0;
  int unsigned n_checks = 0;
  int unsigned n_pass = 0;
  int unsigned exp_q[$];

  interval_timer #(
    .CLK_DIV(DIV),
    .VALUE_W(4),
    .BASE_DEFAULT(6),
    .EXT_DEFAULT(3),
    .YEL_DEFAULT(2)
  ) dut (
    .clk(clk),
    .sys_reset(sys_reset),
    .prg_sync_in(prg_sync_in),
    .time_param_sel(time_param_sel),
    .time_value(time_value),
    .start_timer(start_timer),
    .interval_address(interval_address),
    .expired(expired)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got === want) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, want, cyc);
  endtask

  // Each observed pulse must match the oldest pending expected cycle.
  always @(negedge clk) begin
    if (expired === 1'b1) begin
      if (exp_q.size() == 0) check("unexpected_expired", 32'd1, 32'd0);
      else check("expiry_cycle", cyc, exp_q.pop_front());
    end
  end

  // One driven cycle: optional program, optional start. A start cancels any
  // pending expiry and schedules a new one n seconds after the load edge.
  task automatic op(input logic prg, input logic [1:0] sel, input logic [3:0] val,
                    input logic st, input logic [1:0] addr, input int unsigned n);
    @(negedge clk);
    prg_sync_in      = prg;
    time_param_sel   = sel;
    time_value       = val;
    start_timer      = st;
    interval_address = addr;
    if (st) begin
      exp_q.delete();
      exp_q.push_back(cyc + 1 + n * DIV);
    end
    @(negedge clk);
    prg_sync_in = 1'b0;
    start_timer = 1'b0;
  endtask

  task automatic wait_done();
    int unsigned b = 0;
    while (exp_q.size() != 0 && b < 200) begin
      @(negedge clk);
      b++;
    end
    if (exp_q.size() != 0) begin
      check("timeout_pending", exp_q.size(), 32'd0);
      exp_q.delete();
    end
    repeat (6) @(negedge clk);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check("reset_expired", {31'd0, expired}, 32'd0);
    sys_reset = 1'b0;

    // Default BASE: 6 s -> 24 edges
    op(1'b0, 2'b00, 4'd0, 1'b1, 2'b00, 6);
    wait_done();

    // Program YEL=5, then restore defaults (YEL=2)
    op(1'b1, 2'b10, 4'd5, 1'b0, 2'b00, 0);
    op(1'b0, 2'b00, 4'd0, 1'b1, 2'b10, 5);
    wait_done();
    op(1'b1, 2'b11, 4'd9, 1'b0, 2'b00, 0);
    op(1'b0, 2'b00, 4'd0, 1'b1, 2'b10, 2);
    wait_done();

    // EXT programmed as 0 behaves as 1 s
    op(1'b1, 2'b01, 4'd0, 1'b0, 2'b00, 0);
    op(1'b0, 2'b00, 4'd0, 1'b1, 2'b01, 1);
    wait_done();
    op(1'b1, 2'b11, 4'd0, 1'b0, 2'b00, 0);

    // Restart at edge 10 of a BASE countdown with EXT: single pulse 12 edges later
    op(1'b0, 2'b00, 4'd0, 1'b1, 2'b00, 6);
    repeat (8) @(negedge clk);
    op(1'b0, 2'b00, 4'd0, 1'b1, 2'b01, 3);
    wait_done();

    // Start coinciding with the final tick of EXT: no pulse, YEL runs instead
    op(1'b0, 2'b00, 4'd0, 1'b1, 2'b01, 3);
    repeat (10) @(negedge clk);
    op(1'b0, 2'b00, 4'd0, 1'b1, 2'b10, 2);
    wait_done();

    // Programming BASE while BASE runs leaves the running countdown alone
    op(1'b0, 2'b00, 4'd0, 1'b1, 2'b00, 6);
    repeat (5) @(negedge clk);
    op(1'b1, 2'b00, 4'd2, 1'b0, 2'b00, 0);
    wait_done();
    op(1'b0, 2'b00, 4'd0, 1'b1, 2'b00, 2);
    wait_done();

    // Write-first: program EXT=4 and start EXT in the same cycle
    op(1'b1, 2'b01, 4'd4, 1'b1, 2'b01, 4);
    wait_done();

    // Address 11 loads BASE (currently 2)
    op(1'b0, 2'b00, 4'd0, 1'b1, 2'b11, 2);
    wait_done();

    // Reset mid-countdown: no pulse, and defaults return
    op(1'b0, 2'b00, 4'd0, 1'b1, 2'b00, 2);
    repeat (3) @(negedge clk);
    sys_reset = 1'b1;
    exp_q.delete();
    @(negedge clk);
    sys_reset = 1'b0;
    for (int i = 0; i < 12; i++) begin
      check("post_reset_quiet", {31'd0, expired}, 32'd0);
      @(negedge clk);
    end
    op(1'b0, 2'b00, 4'd0, 1'b1, 2'b00, 6);
    wait_done();
    op(1'b0, 2'b00, 4'd0, 1'b1, 2'b01, 3);
    wait_done();
    op(1'b0, 2'b00, 4'd0, 1'b1, 2'b10, 2);
    wait_done();

    check("scoreboard_empty", exp_q.size(), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
